// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and one-code-per-press valid/ready output.
// Ports: clk, reset (sync, active-high), row_in[3:0], col_out[3:0], key_code[3:0], key_valid, key_ready.
`timescale 1ns/1ps

module module_keypad_scan #(
  parameter int SETTLE_CYCLES = 4,
  parameter int N             = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [N-1:0]  DB_MAX      = '1;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    sync1;
  logic [3:0]    rows;
  logic [1:0]    col;
  logic [1:0]    col_nxt;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_nxt;
  logic [N-1:0]  db_cnt;
  logic [N-1:0]  db_nxt;
  logic [3:0]    row_pat;
  logic [3:0]    pat_nxt;
  logic [1:0]    row_idx;
  logic [1:0]    ridx_nxt;
  logic [1:0]    col_idx;
  logic [1:0]    cidx_nxt;
  logic [3:0]    code_nxt;
  logic          valid_nxt;
  logic          one_low;
  logic [1:0]    low_idx;

  assign col_out = ~(4'b0001 << col);

  // Only a single low row is a usable key; chords and ghosts fall to default.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    unique case (rows)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 4'hF;
      rows       <= 4'hF;
      state      <= SCAN;
      col        <= 2'd0;
      settle_cnt <= '0;
      db_cnt     <= '0;
      row_pat    <= 4'hF;
      row_idx    <= 2'd0;
      col_idx    <= 2'd0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
    end else begin
      sync1      <= row_in;
      rows       <= sync1;
      state      <= state_nxt;
      col        <= col_nxt;
      settle_cnt <= settle_nxt;
      db_cnt     <= db_nxt;
      row_pat    <= pat_nxt;
      row_idx    <= ridx_nxt;
      col_idx    <= cidx_nxt;
      key_code   <= code_nxt;
      key_valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    settle_nxt = settle_cnt;
    db_nxt     = db_cnt;
    pat_nxt    = row_pat;
    ridx_nxt   = row_idx;
    cidx_nxt   = col_idx;
    code_nxt   = key_code;
    valid_nxt  = key_valid;
    unique case (state)
      SCAN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_nxt = '0;
          if (one_low) begin
            pat_nxt   = rows;
            ridx_nxt  = low_idx;
            cidx_nxt  = col;
            db_nxt    = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        // Any deviation restarts the settle on the same column.
        if (rows != row_pat) begin
          db_nxt     = '0;
          settle_nxt = '0;
          state_nxt  = SCAN;
        end else if (db_cnt != DB_MAX) begin
          db_nxt = db_cnt + 1'b1;
        end else begin
          code_nxt  = {row_idx, col_idx};
          valid_nxt = 1'b1;
          state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (key_ready) begin
          valid_nxt = 1'b0;
          db_nxt    = '0;
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (rows != 4'hF) begin
          db_nxt = '0;
        end else if (db_cnt == DB_MAX) begin
          col_nxt    = col + 2'd1;
          settle_nxt = '0;
          state_nxt  = SCAN;
        end else begin
          db_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Randomized and directed bench for module_keypad_scan with a keypad matrix model.
// Drives a virtual 4x4 keypad from col_out and checks codes, timing and handshake behaviour.
`timescale 1ns/1ps

module tb_module_keypad_scan;

  localparam int SETTLE = 4;
  localparam int NB     = 4;
  localparam int DB     = 1 << NB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b1;

  logic [15:0] keys = '0;
  logic [3:0]  glitch = '0;
  bit          rnd_rdy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int vseen = 0;
  logic [3:0] last_code = '0;
  logic       stall_prev = 1'b0;
  logic [3:0] stall_code = '0;

  module_keypad_scan #(
    .SETTLE_CYCLES(SETTLE),
    .N(NB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low while its column is driven.
  function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (k[i*4+j] && !c[j]) r[i] = 1'b0;
    return r;
  endfunction

  assign row_in = pad(keys, col_out) & ~glitch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(key_valid), 1);
        chk("stall_code", 32'(key_code), 32'(stall_code));
      end
      if (key_valid && key_ready) begin
        hs_cnt++;
        last_code = key_code;
      end
      stall_prev = key_valid && !key_ready;
      stall_code = key_code;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) vseen++;
      if (rnd_rdy) key_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int t);
    t = 0;
    while (!key_valid && t < budget) begin
      step(1);
      t++;
    end
    chk(tag, 32'(key_valid), 1);
  endtask

  function automatic int key_of(input int r, input int c);
    return r * 4 + c;
  endfunction

  task automatic bounce(input int k, input int n);
    for (int b = 0; b < n; b++) begin
      keys = 16'h1 << k;
      step($urandom_range(1, 5));
      keys = '0;
      step($urandom_range(1, 5));
    end
  endtask

  initial begin
    int h0;
    int t;
    int k;
    int exp_code;

    // Reset state
    step(3);
    chk("rst_col", 32'(col_out), 32'hE);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);

    // Key on column 0 held across reset release: valid after edge SETTLE+DB
    keys = 16'h1 << key_of(1, 0);
    step(2);
    reset = 1'b0;
    h0 = hs_cnt;
    for (int e = 1; e <= SETTLE + DB + 1; e++) begin
      step(1);
      if (e == SETTLE + DB - 1) chk("a_pre", 32'(key_valid), 0);
      if (e == SETTLE + DB) begin
        chk("a_valid", 32'(key_valid), 1);
        chk("a_code", 32'(key_code), key_of(1, 0));
      end
      if (e == SETTLE + DB + 1) chk("a_pulse", 32'(key_valid), 0);
    end
    keys = '0;
    step(40);
    chk("a_xfer", hs_cnt - h0, 1);

    // Key 6 clean from reset, ready high
    @(negedge clk);
    reset = 1'b1;
    keys = 16'h1 << key_of(1, 2);
    step(2);
    reset = 1'b0;
    h0 = hs_cnt;
    vseen = 0;
    wait_valid("b_seen", 100, t);
    chk("b_code", 32'(key_code), key_of(1, 2));
    step(150);
    chk("b_xfer", hs_cnt - h0, 1);
    chk("b_vlen", vseen, 1);
    keys = '0;
    step(2 + DB - 1);
    chk("b_hold_col", 32'(col_out), 32'hB);
    step(1);
    chk("b_next_col", 32'(col_out), 32'h7);
    step(20);

    // Key 15 with bounces before settling
    h0 = hs_cnt;
    vseen = 0;
    bounce(key_of(3, 3), 10);
    chk("c_early", vseen, 0);
    keys = 16'h1 << key_of(3, 3);
    wait_valid("c_seen", 200, t);
    chk("c_lat_min", 32'(t >= 2 + DB), 1);
    chk("c_code", 32'(key_code), key_of(3, 3));
    step(40);
    keys = '0;
    bounce(key_of(3, 3), 3);
    step(40);
    chk("c_xfer", hs_cnt - h0, 1);
    chk("c_last", 32'(last_code), key_of(3, 3));

    // Key 9 stalled for 50 cycles, released meanwhile
    key_ready = 1'b0;
    h0 = hs_cnt;
    keys = 16'h1 << key_of(2, 1);
    wait_valid("d_seen", 100, t);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) keys = '0;
      step(1);
      chk("d_valid", 32'(key_valid), 1);
      chk("d_code", 32'(key_code), key_of(2, 1));
    end
    key_ready = 1'b1;
    step(1);
    chk("d_drop", 32'(key_valid), 0);
    step(DB - 1);
    chk("d_rel_col", 32'(col_out), 32'hD);
    step(1);
    chk("d_scan_col", 32'(col_out), 32'hB);
    chk("d_xfer", hs_cnt - h0, 1);
    chk("d_last", 32'(last_code), key_of(2, 1));
    step(10);

    // Ghost: rows 0 and 2 on column 1
    h0 = hs_cnt;
    keys = (16'h1 << key_of(0, 1)) | (16'h1 << key_of(2, 1));
    step(10);
    vseen = 0;
    t = 0;
    while (col_out == 4'hE && t < 40) begin
      step(1);
      t++;
    end
    while (col_out != 4'hE && t < 40) begin
      step(1);
      t++;
    end
    chk("e_align", 32'(col_out), 32'hE);
    for (int j = 1; j <= 16; j++) begin
      step(1);
      chk("e_col", 32'(col_out), 32'(~(4'b0001 << ((j / SETTLE) % 4)) & 4'hF));
    end
    chk("e_novalid", vseen, 0);
    chk("e_xfer", hs_cnt - h0, 0);
    keys = '0;
    step(20);

    // Reset while PRESSED with key 5 held
    key_ready = 1'b0;
    keys = 16'h1 << key_of(1, 1);
    wait_valid("f_seen", 100, t);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("f_valid", 32'(key_valid), 0);
    chk("f_col", 32'(col_out), 32'hE);
    key_ready = 1'b1;
    h0 = hs_cnt;
    for (int e = 1; e <= 2 * SETTLE + DB; e++) begin
      step(1);
      if (e == 2 * SETTLE + DB - 1) chk("f_pre", 32'(key_valid), 0);
      if (e == 2 * SETTLE + DB) begin
        chk("f_re", 32'(key_valid), 1);
        chk("f_code", 32'(key_code), key_of(1, 1));
      end
    end
    keys = '0;
    step(40);
    chk("f_xfer", hs_cnt - h0, 1);

    // Two-cycle row glitch at the column-0 sample point
    @(negedge clk);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    vseen = 0;
    step(1);
    glitch = 4'b0100;
    step(2);
    glitch = 4'b0000;
    step(6);
    chk("g_same_col", 32'(col_out), 32'hE);
    step(1);
    chk("g_next_col", 32'(col_out), 32'hD);
    chk("g_novalid", vseen, 0);
    step(20);

    // Randomized presses with bounce and random back-pressure
    rnd_rdy = 1'b1;
    for (int ep = 0; ep < 12; ep++) begin
      k = $urandom_range(0, 15);
      exp_code = key_of(k / 4, k % 4);
      h0 = hs_cnt;
      bounce(k, $urandom_range(0, 4));
      keys = 16'h1 << k;
      step($urandom_range(60, 100));
      keys = '0;
      bounce(k, $urandom_range(0, 3));
      rnd_rdy = 1'b0;
      key_ready = 1'b1;
      t = 0;
      while (hs_cnt == h0 && t < 50) begin
        step(1);
        t++;
      end
      step(30);
      rnd_rdy = 1'b1;
      chk("rnd_xfer", hs_cnt - h0, 1);
      chk("rnd_code", 32'(last_code), exp_code);
    end
    rnd_rdy = 1'b0;
    key_ready = 1'b1;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
